adpll_lock_detect_5bit: RTL

Lock detector for the 5-bit ADPLL, placed directly downstream of the loop top level. It samples `clk_ref` and the loop's `fb_clk` in the system `clk` domain and measures the rising-edge phase error in `clk` cycles. It also checks that the 5-bit sign-magnitude loop-filter word (`filter_out`/`filter_sign`) is stable. From these it runs a lock/slip state machine, giving software and test logic a clean `locked` indication plus the raw phase measurement.

---
 rtl/adpll_lock_detect_5bit.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/adpll_lock_detect_5bit.sv
`default_nettype none
// ============================================================================
//  Module      : adpll_lock_detect_5bit
//  Description : Lock detector for the 5-bit ADPLL. Measures the rising-edge
//                phase error between clk_ref and fb_clk in clk cycles, checks
//                loop-filter word stability, and runs a lock/slip FSM with a
//                reference-loss watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module adpll_lock_detect_5bit #(
    parameter int UNLOCK_BAD  = 3,
    parameter int REF_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       clk_ref,
    input  logic       fb_clk,
    input  logic [4:0] filter_out,
    input  logic       filter_sign,
    input  logic [4:0] lock_tol,
    input  logic [4:0] lock_cnt_thresh,
    output logic       locked,
    output logic [1:0] lock_state,
    output logic [4:0] phase_err,
    output logic       phase_lead,
    output logic       meas_valid,
    output logic       ref_lost
);

    // Measurement FSM encoding
    localparam logic [1:0] c_MS_IDLE     = 2'd0;
    localparam logic [1:0] c_MS_WAIT_FB  = 2'd1;
    localparam logic [1:0] c_MS_WAIT_REF = 2'd2;

    // Lock FSM encoding (visible on lock_state)
    localparam logic [1:0] c_LK_UNLOCKED = 2'b00;
    localparam logic [1:0] c_LK_ACQUIRE  = 2'b01;
    localparam logic [1:0] c_LK_LOCKED   = 2'b10;
    localparam logic [1:0] c_LK_SLIP     = 2'b11;

    localparam logic [4:0] c_ERR_MAX    = 5'd31;
    localparam logic [4:0] c_UNLOCK_BAD = 5'(UNLOCK_BAD);
    // Watchdog fires on the cycle the counter would step onto REF_TIMEOUT
    localparam logic [7:0] c_WD_LAST    = 8'(REF_TIMEOUT - 1);

    // Synchroniser and history flops
    logic       r_ref_s1, r_ref_s2, r_ref_s3;
    logic       r_fb_s1, r_fb_s2, r_fb_s3;

    // Measurement path
    logic [1:0] r_ms_state;
    logic [4:0] r_cnt;
    logic [4:0] r_phase_err;
    logic       r_phase_lead;
    logic       r_meas_valid;

    // Watchdog
    logic [7:0] r_wd_cnt;
    logic       r_ref_lost;

    // Lock path
    logic [1:0] r_lk_state;
    logic       r_locked;
    logic [4:0] r_good_cnt;
    logic [3:0] r_bad_cnt;
    logic [5:0] r_fsnap;
    logic       r_snap_valid;

    logic       w_ref_edge;
    logic       w_fb_edge;
    logic       w_wd_expire;
    logic [4:0] w_cnt_inc;
    logic [5:0] w_f_now;
    logic [6:0] w_f_diff;
    logic       w_f_stable;
    logic       w_good;
    logic [4:0] w_thresh_eff;
    logic [5:0] w_good_inc;
    logic       w_good_done;
    logic [4:0] w_bad_inc;
    logic       w_bad_done;

    assign w_ref_edge  = r_ref_s2 & ~r_ref_s3;
    assign w_fb_edge   = r_fb_s2 & ~r_fb_s3;
    assign w_wd_expire = enable && !w_ref_edge && (r_wd_cnt == c_WD_LAST);

    // Edge distance is cnt+1 at the closing edge, saturating at 31
    assign w_cnt_inc   = (r_cnt == c_ERR_MAX) ? c_ERR_MAX : (r_cnt + 5'd1);

    // Sign-magnitude to 6-bit two's complement; -0 folds onto +0 naturally
    assign w_f_now     = filter_sign ? (6'd0 - {1'b0, filter_out}) : {1'b0, filter_out};
    assign w_f_diff    = {w_f_now[5], w_f_now} - {r_fsnap[5], r_fsnap};
    assign w_f_stable  = (w_f_diff == 7'd0) || (w_f_diff == 7'd1) || (w_f_diff == 7'h7F);

    assign w_good       = (r_phase_err <= lock_tol) && (!r_snap_valid || w_f_stable);
    assign w_thresh_eff = (lock_cnt_thresh == 5'd0) ? 5'd1 : lock_cnt_thresh;
    assign w_good_inc   = {1'b0, r_good_cnt} + 6'd1;
    assign w_good_done  = (w_good_inc >= {1'b0, w_thresh_eff});
    assign w_bad_inc    = {1'b0, r_bad_cnt} + 5'd1;
    assign w_bad_done   = (w_bad_inc >= c_UNLOCK_BAD);

    // Two-flop synchronisers plus history flop; these keep running when disabled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ref_s1 <= 1'b0;
            r_ref_s2 <= 1'b0;
            r_ref_s3 <= 1'b0;
            r_fb_s1  <= 1'b0;
            r_fb_s2  <= 1'b0;
            r_fb_s3  <= 1'b0;
        end else begin
            r_ref_s1 <= clk_ref;
            r_ref_s2 <= r_ref_s1;
            r_ref_s3 <= r_ref_s2;
            r_fb_s1  <= fb_clk;
            r_fb_s2  <= r_fb_s1;
            r_fb_s3  <= r_fb_s2;
        end
    end

    // Reference watchdog: cleared by each ref edge, saturating otherwise
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_wd_cnt   <= 8'd0;
            r_ref_lost <= 1'b0;
        end else if (w_ref_edge) begin
            r_wd_cnt   <= 8'd0;
            r_ref_lost <= 1'b0;
        end else begin
            if (r_wd_cnt != 8'hFF) begin
                r_wd_cnt <= r_wd_cnt + 8'd1;
            end
            if (w_wd_expire) begin
                r_ref_lost <= 1'b1;
            end
        end
    end

    // Measurement FSM: times the gap between the two edges and registers the result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_state   <= c_MS_IDLE;
            r_cnt        <= 5'd0;
            r_phase_err  <= 5'd0;
            r_phase_lead <= 1'b0;
            r_meas_valid <= 1'b0;
        end else if (!enable || w_wd_expire) begin
            // Partial measurement is discarded
            r_ms_state   <= c_MS_IDLE;
            r_cnt        <= 5'd0;
            r_meas_valid <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            case (r_ms_state)
                c_MS_IDLE: begin
                    r_cnt <= 5'd0;
                    if (w_ref_edge && w_fb_edge) begin
                        r_phase_err  <= 5'd0;
                        r_phase_lead <= 1'b0;
                        r_meas_valid <= 1'b1;
                    end else if (w_ref_edge) begin
                        r_ms_state <= c_MS_WAIT_FB;
                    end else if (w_fb_edge) begin
                        r_ms_state <= c_MS_WAIT_REF;
                    end
                end
                c_MS_WAIT_FB: begin
                    if (w_fb_edge) begin
                        r_phase_err  <= w_cnt_inc;
                        r_phase_lead <= 1'b0;
                        r_meas_valid <= 1'b1;
                        r_ms_state   <= c_MS_IDLE;
                    end else if (w_ref_edge) begin
                        // Second ref edge with no fb: report worst case and start over
                        r_phase_err  <= c_ERR_MAX;
                        r_phase_lead <= 1'b0;
                        r_meas_valid <= 1'b1;
                        r_cnt        <= 5'd0;
                    end else if (r_cnt == c_ERR_MAX) begin
                        r_phase_err  <= c_ERR_MAX;
                        r_phase_lead <= 1'b0;
                        r_meas_valid <= 1'b1;
                        r_ms_state   <= c_MS_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                c_MS_WAIT_REF: begin
                    if (w_ref_edge) begin
                        r_phase_err  <= w_cnt_inc;
                        r_phase_lead <= 1'b1;
                        r_meas_valid <= 1'b1;
                        r_ms_state   <= c_MS_IDLE;
                    end else if (w_fb_edge) begin
                        r_phase_err  <= c_ERR_MAX;
                        r_phase_lead <= 1'b1;
                        r_meas_valid <= 1'b1;
                        r_cnt        <= 5'd0;
                    end else if (r_cnt == c_ERR_MAX) begin
                        r_phase_err  <= c_ERR_MAX;
                        r_phase_lead <= 1'b1;
                        r_meas_valid <= 1'b1;
                        r_ms_state   <= c_MS_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_ms_state <= c_MS_IDLE;
                    r_cnt      <= 5'd0;
                end
            endcase
        end
    end

    // Lock FSM: advances only on meas_valid; a watchdog expiry overrides it
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_lk_state   <= c_LK_UNLOCKED;
            r_locked     <= 1'b0;
            r_good_cnt   <= 5'd0;
            r_bad_cnt    <= 4'd0;
            r_fsnap      <= 6'd0;
            r_snap_valid <= 1'b0;
        end else if (w_wd_expire) begin
            r_lk_state   <= c_LK_UNLOCKED;
            r_locked     <= 1'b0;
            r_good_cnt   <= 5'd0;
            r_bad_cnt    <= 4'd0;
            r_snap_valid <= 1'b0;
        end else if (r_meas_valid) begin
            r_fsnap      <= w_f_now;
            r_snap_valid <= 1'b1;
            case (r_lk_state)
                c_LK_UNLOCKED: begin
                    if (w_good) begin
                        if (w_thresh_eff == 5'd1) begin
                            r_lk_state <= c_LK_LOCKED;
                            r_locked   <= 1'b1;
                            r_good_cnt <= 5'd0;
                        end else begin
                            r_lk_state <= c_LK_ACQUIRE;
                            r_good_cnt <= 5'd1;
                        end
                    end
                end
                c_LK_ACQUIRE: begin
                    if (!w_good) begin
                        r_lk_state <= c_LK_UNLOCKED;
                        r_good_cnt <= 5'd0;
                    end else if (w_good_done) begin
                        r_lk_state <= c_LK_LOCKED;
                        r_locked   <= 1'b1;
                        r_good_cnt <= 5'd0;
                    end else begin
                        r_good_cnt <= w_good_inc[4:0];
                    end
                end
                c_LK_LOCKED: begin
                    if (!w_good) begin
                        r_lk_state <= c_LK_SLIP;
                        r_bad_cnt  <= 4'd1;
                    end
                end
                c_LK_SLIP: begin
                    if (w_good) begin
                        r_lk_state <= c_LK_LOCKED;
                        r_bad_cnt  <= 4'd0;
                    end else if (w_bad_done) begin
                        r_lk_state   <= c_LK_UNLOCKED;
                        r_locked     <= 1'b0;
                        r_good_cnt   <= 5'd0;
                        r_bad_cnt    <= 4'd0;
                        r_snap_valid <= 1'b0;
                    end else begin
                        r_bad_cnt <= w_bad_inc[3:0];
                    end
                end
                default: begin
                    r_lk_state <= c_LK_UNLOCKED;
                    r_locked   <= 1'b0;
                end
            endcase
        end
    end

    assign locked     = r_locked;
    assign lock_state = r_lk_state;
    assign phase_err  = r_phase_err;
    assign phase_lead = r_phase_lead;
    assign meas_valid = r_meas_valid;
    assign ref_lost   = r_ref_lost;

endmodule
`default_nettype wire
